// File: rtl/bus85_pkg.sv
// Shared definitions for the 8085-style bus responder: state encoding,
// register-window geometry and strobe polarities used by the core's bus side.
package bus85_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_DATA,
    S_DONE
  } state_t;

  localparam int WIN_W    = 4;
  localparam int MAX_WAIT = 15;

  localparam logic STROBE_ACT = 1'b0;
  localparam logic ALE_ACT    = 1'b1;

  function automatic logic strobe_on(input logic s_n);
    return s_n == STROBE_ACT;
  endfunction

endpackage

// File: rtl/bus_slave85_if.sv
// Multiplexed AD bus plus event taps seen by one bus_slave85 instance.
// BUS_SLAVE85_HOLD_EN adds the HOLD request/grant signals.
interface bus_slave85_if;
  logic [7:0]                  addrhi;
  logic [7:0]                  adin;
  logic [7:0]                  adout;
  logic                        adoe;
  logic                        ale;
  logic                        rd_n;
  logic                        wr_n;
  logic                        iom;
  logic                        ready;
  logic                        evt_wr;
  logic [bus85_pkg::WIN_W-1:0] evt_addr;
  logic [7:0]                  evt_data;
`ifdef BUS_SLAVE85_HOLD_EN
  logic                        hreq;
  logic                        hlda;
  logic                        hold;
  logic                        hgnt;
`endif

  modport master (
    output addrhi, adin, ale, rd_n, wr_n, iom,
    input  adout, adoe, ready, evt_wr, evt_addr, evt_data
`ifdef BUS_SLAVE85_HOLD_EN
    , output hreq, hlda,
    input  hold, hgnt
`endif
  );

  modport slave (
    input  addrhi, adin, ale, rd_n, wr_n, iom,
    output adout, adoe, ready, evt_wr, evt_addr, evt_data
`ifdef BUS_SLAVE85_HOLD_EN
    , input hreq, hlda,
    output hold, hgnt
`endif
  );
endinterface

// File: rtl/reg_file16.sv
// 16x8 register file: one synchronous write port, one async read port,
// cleared by reset.
module reg_file16
  import bus85_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             we,
  input  logic [WIN_W-1:0] waddr,
  input  logic [7:0]       wdata,
  input  logic [WIN_W-1:0] raddr,
  output logic [7:0]       rdata
);

  logic [(1<<WIN_W)-1:0][7:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) mem_q <= '0;
    else       mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/bus_slave85.sv
// 8085-style bus responder: ALE address latch, 16-byte window decode, READY
// wait stretching, read drive / write capture. Optional HOLD requester
// enabled by BUS_SLAVE85_HOLD_EN.
module bus_slave85
  import bus85_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR = 8'h20,
  parameter logic        IO_SPACE  = 1'b0,
  parameter int unsigned WAIT_CYC  = 1
) (
  input  logic          clock,
  input  logic          reset,
  bus_slave85_if.slave  bus
);

  localparam int unsigned WAIT_CLAMP = (WAIT_CYC > MAX_WAIT) ? MAX_WAIT : WAIT_CYC;
  localparam logic [3:0]  WAIT_LD    = WAIT_CLAMP[3:0];

  state_t           state_q, state_d;
  logic [WIN_W-1:0] idx_q, idx_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             rnw_q, rnw_d;
  logic             ready_q, ready_d;
  logic             adoe_q, adoe_d;
  logic [7:0]       adout_q, adout_d;
  logic             evt_wr_q, evt_wr_d;
  logic [WIN_W-1:0] evt_addr_q, evt_addr_d;
  logic [7:0]       evt_data_q, evt_data_d;

  logic             rf_we;
  logic [7:0]       rf_rdata;
  logic             ale_on, rd_on, wr_on, sel, enter_data;

  reg_file16 u_rf (
    .clock (clock),
    .reset (reset),
    .we    (rf_we),
    .waddr (idx_q),
    .wdata (bus.adin),
    .raddr (idx_q),
    .rdata (rf_rdata)
  );

`ifdef BUS_SLAVE85_HOLD_EN
  logic hold_q, hold_d, hgnt_q, hgnt_d;

  // hold only rises from IDLE but falls as soon as the local request goes away
  always_comb begin
    hold_d = hold_q;
    if (!bus.hreq)              hold_d = 1'b0;
    else if (state_q == S_IDLE) hold_d = 1'b1;
    hgnt_d = hold_d & bus.hlda;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_q <= 1'b0;
      hgnt_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      hgnt_q <= hgnt_d;
    end
  end

  assign bus.hold = hold_q;
  assign bus.hgnt = hgnt_q;
  assign ale_on   = (bus.ale == ALE_ACT) & ~hgnt_q;
`else
  assign ale_on   = (bus.ale == ALE_ACT);
`endif

  assign rd_on = strobe_on(bus.rd_n);
  assign wr_on = strobe_on(bus.wr_n);
  assign sel   = (bus.addrhi == BASE_ADDR) && (bus.adin[7:4] == 4'h0) && (bus.iom == IO_SPACE);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    rnw_d      = rnw_q;
    ready_d    = 1'b1;
    adoe_d     = adoe_q;
    adout_d    = adout_q;
    evt_wr_d   = 1'b0;
    evt_addr_d = evt_addr_q;
    evt_data_d = evt_data_q;
    rf_we      = 1'b0;
    enter_data = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (ale_on) begin
          idx_d = bus.adin[WIN_W-1:0];
          if (sel) state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (ale_on) begin
          idx_d   = bus.adin[WIN_W-1:0];
          state_d = sel ? S_ADDR : S_IDLE;
        end else if (rd_on && wr_on) begin
          // contending strobes: abandon the cycle without touching the bus
          state_d = S_DONE;
        end else if (rd_on || wr_on) begin
          rnw_d = rd_on;
          if (WAIT_LD != 4'd0) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LD;
            ready_d = 1'b0;
          end else begin
            enter_data = 1'b1;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) enter_data = 1'b1;
        else               ready_d    = 1'b0;
      end
      S_DATA: begin
        if (!rnw_q) begin
          rf_we      = 1'b1;
          evt_wr_d   = 1'b1;
          evt_data_d = bus.adin;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (!rd_on && !wr_on) begin
          state_d = S_IDLE;
          adoe_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (enter_data) begin
      state_d    = S_DATA;
      evt_addr_d = idx_q;
      if (rnw_d) begin
        adoe_d  = 1'b1;
        adout_d = rf_rdata;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      rnw_q      <= 1'b0;
      ready_q    <= 1'b1;
      adoe_q     <= 1'b0;
      adout_q    <= '0;
      evt_wr_q   <= 1'b0;
      evt_addr_q <= '0;
      evt_data_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      rnw_q      <= rnw_d;
      ready_q    <= ready_d;
      adoe_q     <= adoe_d;
      adout_q    <= adout_d;
      evt_wr_q   <= evt_wr_d;
      evt_addr_q <= evt_addr_d;
      evt_data_q <= evt_data_d;
    end
  end

  assign bus.ready    = ready_q;
  assign bus.adoe     = adoe_q;
  assign bus.adout    = adout_q;
  assign bus.evt_wr   = evt_wr_q;
  assign bus.evt_addr = evt_addr_q;
  assign bus.evt_data = evt_data_q;

endmodule

// File: tb/tb_bus_slave85.sv
// Directed bench: three responders (WAIT_CYC 0/1/3) share one bus stimulus;
// expected values are hand-derived per step.
module tb_bus_slave85;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] addrhi = 8'h00, adin = 8'h00;
  logic       ale = 1'b0, rd_n = 1'b1, wr_n = 1'b1, iom = 1'b0;
`ifdef BUS_SLAVE85_HOLD_EN
  logic       hreq = 1'b0, hlda = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  bus_slave85_if i0 ();
  bus_slave85_if i1 ();
  bus_slave85_if i3 ();

  assign i0.addrhi = addrhi; assign i0.adin = adin; assign i0.ale = ale;
  assign i0.rd_n = rd_n; assign i0.wr_n = wr_n; assign i0.iom = iom;
  assign i1.addrhi = addrhi; assign i1.adin = adin; assign i1.ale = ale;
  assign i1.rd_n = rd_n; assign i1.wr_n = wr_n; assign i1.iom = iom;
  assign i3.addrhi = addrhi; assign i3.adin = adin; assign i3.ale = ale;
  assign i3.rd_n = rd_n; assign i3.wr_n = wr_n; assign i3.iom = iom;
`ifdef BUS_SLAVE85_HOLD_EN
  assign i0.hreq = hreq; assign i0.hlda = hlda;
  assign i1.hreq = hreq; assign i1.hlda = hlda;
  assign i3.hreq = hreq; assign i3.hlda = hlda;
`endif

  bus_slave85 #(.BASE_ADDR(8'h20), .IO_SPACE(1'b0), .WAIT_CYC(0)) u0 (.clock(clock), .reset(reset), .bus(i0.slave));
  bus_slave85 #(.BASE_ADDR(8'h20), .IO_SPACE(1'b0), .WAIT_CYC(1)) u1 (.clock(clock), .reset(reset), .bus(i1.slave));
  bus_slave85 #(.BASE_ADDR(8'h20), .IO_SPACE(1'b0), .WAIT_CYC(3)) u3 (.clock(clock), .reset(reset), .bus(i3.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic addr_phase(input logic [7:0] hi, input logic [7:0] lo, input logic io);
    ale = 1'b1; addrhi = hi; adin = lo; iom = io;
    tick();
    ale = 1'b0;
  endtask

  initial begin
    int pulses;
    int bad;
    logic [7:0] uh [3];
    logic [7:0] ul [3];
    logic       ui [3];

    // reset values
    tick(); tick();
    chk("rst_ready",    i1.ready,    1);
    chk("rst_adoe",     i1.adoe,     0);
    chk("rst_adout",    i1.adout,    0);
    chk("rst_evt_wr",   i1.evt_wr,   0);
    chk("rst_evt_addr", i1.evt_addr, 0);
    chk("rst_evt_data", i1.evt_data, 0);
    reset = 1'b0;
    tick();

    // preload reg[3] = A5 in all three responders
    addr_phase(8'h20, 8'h03, 1'b0);
    adin = 8'hA5; wr_n = 1'b0;
    repeat (6) tick();
    wr_n = 1'b1;
    repeat (2) tick();
    chk("pre_evt_data3", i3.evt_data, 8'hA5);
    chk("pre_evt_addr3", i3.evt_addr, 4'h3);

    // read reg[3]: WAIT 0/1/3 latencies side by side
    addr_phase(8'h20, 8'h03, 1'b0);
    rd_n = 1'b0;
    tick();                                   // strobe sampled
    chk("rd_w1_ready_e0", i1.ready, 0);
    chk("rd_w1_adoe_e0",  i1.adoe,  0);
    chk("rd_w3_ready_e0", i3.ready, 0);
    chk("rd_w0_adoe_e0",  i0.adoe,  1);
    chk("rd_w0_adout_e0", i0.adout, 8'hA5);
    tick();
    chk("rd_w1_ready_e1", i1.ready, 1);
    chk("rd_w1_adoe_e1",  i1.adoe,  1);
    chk("rd_w1_adout_e1", i1.adout, 8'hA5);
    chk("rd_w1_evt_addr", i1.evt_addr, 4'h3);
    chk("rd_w3_ready_e1", i3.ready, 0);
    tick();
    chk("rd_w3_ready_e2", i3.ready, 0);
    chk("rd_w1_adoe_hold", i1.adoe, 1);
    tick();
    chk("rd_w3_ready_e3", i3.ready, 1);
    chk("rd_w3_adoe_e3",  i3.adoe,  1);
    chk("rd_w3_adout_e3", i3.adout, 8'hA5);
    rd_n = 1'b1;
    tick();
    chk("rd_w1_adoe_drop", i1.adoe, 0);
    chk("rd_w3_adoe_done", i3.adoe, 1);
    tick();
    chk("rd_w3_adoe_drop", i3.adoe, 0);
    tick();

    // write 0x2007 <= 5A, WAIT 0
    addr_phase(8'h20, 8'h07, 1'b0);
    adin = 8'h5A; wr_n = 1'b0;
    tick();
    chk("wr_w0_ready_e0",  i0.ready,  1);
    chk("wr_w0_evt_wr_e0", i0.evt_wr, 0);
    tick();
    chk("wr_w0_evt_wr",   i0.evt_wr,   1);
    chk("wr_w0_evt_addr", i0.evt_addr, 4'h7);
    chk("wr_w0_evt_data", i0.evt_data, 8'h5A);
    chk("wr_w0_ready_e1", i0.ready,    1);
    pulses = 0;
    repeat (4) begin
      tick();
      if (i0.evt_wr !== 1'b0) pulses++;
    end
    chk("wr_w0_evt_wr_once", pulses, 0);
    wr_n = 1'b1;
    repeat (2) tick();
    addr_phase(8'h20, 8'h07, 1'b0);
    rd_n = 1'b0;
    tick();
    chk("rdback_adoe",  i0.adoe,  1);
    chk("rdback_adout", i0.adout, 8'h5A);
    repeat (4) tick();
    rd_n = 1'b1;
    repeat (2) tick();

    // unselected cycles: wrong page, index out of window, wrong space
    uh[0] = 8'h21; ul[0] = 8'h03; ui[0] = 1'b0;
    uh[1] = 8'h20; ul[1] = 8'h13; ui[1] = 1'b0;
    uh[2] = 8'h20; ul[2] = 8'h03; ui[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      addr_phase(uh[k], ul[k], ui[k]);
      if (k == 1) wr_n = 1'b0; else rd_n = 1'b0;
      bad = 0;
      repeat (5) begin
        tick();
        if (i1.ready !== 1'b1 || i1.adoe !== 1'b0 || i1.evt_wr !== 1'b0) bad++;
      end
      rd_n = 1'b1; wr_n = 1'b1;
      tick();
      chk($sformatf("unsel_%0d", k), bad, 0);
    end
    iom = 1'b0;
    addr_phase(8'h20, 8'h03, 1'b0);
    rd_n = 1'b0;
    tick();
    chk("unsel_reg3_kept", i0.adout, 8'hA5);
    repeat (4) tick();
    rd_n = 1'b1;
    repeat (2) tick();

    // both strobes low: no write, no drive
    addr_phase(8'h20, 8'h05, 1'b0);
    adin = 8'h77; rd_n = 1'b0; wr_n = 1'b0;
    tick();
    chk("both_adoe",  i1.adoe,  0);
    chk("both_ready", i1.ready, 1);
    bad = 0;
    repeat (3) begin
      tick();
      if (i1.evt_wr !== 1'b0 || i1.adoe !== 1'b0) bad++;
    end
    chk("both_quiet", bad, 0);
    rd_n = 1'b1; wr_n = 1'b1;
    tick();
    addr_phase(8'h20, 8'h05, 1'b0);
    rd_n = 1'b0;
    tick();
    chk("both_back_idle", i0.adoe,  1);
    chk("both_no_write",  i0.adout, 8'h00);
    repeat (4) tick();
    rd_n = 1'b1;
    repeat (2) tick();

    // reset asserted while the WAIT 3 responder is in WAIT
    addr_phase(8'h20, 8'h03, 1'b0);
    rd_n = 1'b0;
    tick();
    tick();
    chk("mid_w3_ready_pre", i3.ready, 0);
    chk("mid_w1_adoe_pre",  i1.adoe,  1);
    #2 reset = 1'b1;
    #1;
    chk("mid_w3_ready_rst", i3.ready, 1);
    chk("mid_w3_adoe_rst",  i3.adoe,  0);
    chk("mid_w1_adoe_rst",  i1.adoe,  0);
    rd_n = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    addr_phase(8'h20, 8'h03, 1'b0);
    rd_n = 1'b0;
    tick();
    chk("mid_reg_cleared_adoe", i0.adoe,  1);
    chk("mid_reg_cleared",      i0.adout, 8'h00);
    repeat (4) tick();
    rd_n = 1'b1;
    repeat (2) tick();

`ifdef BUS_SLAVE85_HOLD_EN
    hreq = 1'b1;
    tick();
    chk("hold_set", i1.hold, 1);
    chk("hgnt_pre", i1.hgnt, 0);
    hlda = 1'b1;
    tick();
    chk("hgnt_set", i1.hgnt, 1);
    addr_phase(8'h20, 8'h03, 1'b0);
    rd_n = 1'b0;
    tick();
    chk("hold_ale_ign_ready", i1.ready, 1);
    tick();
    chk("hold_ale_ign_adoe", i1.adoe, 0);
    rd_n = 1'b1; hreq = 1'b0;
    tick();
    chk("hold_clr", i1.hold, 0);
    chk("hgnt_clr", i1.hgnt, 0);
    hlda = 1'b0;
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
